v_dff: RTL and testbench

Parameterised resettable register (flip-flop bank) used as a pipeline register throughout the datapath. It is used, for example, for stage control words and valid/“do” flags, which must clear to a bubble on reset. It is the resettable counterpart of the non-reset data register vDFF_nr. An optional STAGES parameter builds a chain of identical registers for multi-cycle delays.

---
 rtl/v_dff_pkg.sv | 14 +
 rtl/v_dff_stage.sv | 17 +
 rtl/v_dff.sv | 39 +++
 tb/tb_v_dff.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/v_dff_pkg.sv
// Shared pipeline constants: legal parameter ranges for the register banks
// and the common control-word width used by the datapath stages.
package v_dff_pkg;

  localparam int WIDTH_MAX  = 1024;
  localparam int STAGES_MAX = 64;
  localparam int CTRL_W     = 22;

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (width <= WIDTH_MAX) &&
           (stages >= 1) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/v_dff_stage.sv
// Single WIDTH-bit register with asynchronous active-low reset to RST_VAL.
module v_dff_stage #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out <= RST_VAL;
    else      out <= in;
  end

endmodule

// File: rtl/v_dff.sv
// Resettable pipeline register: a chain of STAGES identical register stages,
// every stage clearing to RST_VAL the moment rst goes low.
module v_dff
  import v_dff_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $fatal(1, "v_dff: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  // chain[0] is the input tap, chain[k] the output of stage k-1
  logic [STAGES:0][WIDTH-1:0] chain;

  assign chain[0] = in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    v_dff_stage #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .in (chain[k]),
      .out(chain[k+1])
    );
  end

  assign out = chain[STAGES];

endmodule

// File: tb/tb_v_dff.sv
// Bench for v_dff: several parameterisations sharing one clock, with
// directed tables, hand-written reset sequences and a randomized run.
module tb_v_dff;

  localparam int               E_W  = 13;
  localparam int               E_S  = 5;
  localparam logic [E_W-1:0]   E_RV = 13'h1A5B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1, rst_e = 1'b1;
  logic [21:0] in_a = '0, out_a;
  logic        in_b = 1'b0, out_b;
  logic [7:0]  in_c = '0, out_c;
  logic [3:0]  in_d = '0, out_d;
  logic [E_W-1:0] in_e = '0, out_e;

  v_dff #(.WIDTH(22), .STAGES(1)) dut_a (.clk(clk), .rst(rst_a), .in(in_a), .out(out_a));
  v_dff                           dut_b (.clk(clk), .rst(rst_b), .in(in_b), .out(out_b));
  v_dff #(.WIDTH(8), .STAGES(3))  dut_c (.clk(clk), .rst(rst_c), .in(in_c), .out(out_c));
  v_dff #(.WIDTH(4), .STAGES(1), .RST_VAL(4'hA)) dut_d (.clk(clk), .rst(rst_d), .in(in_d), .out(out_d));
  v_dff #(.WIDTH(E_W), .STAGES(E_S), .RST_VAL(E_RV)) dut_e (.clk(clk), .rst(rst_e), .in(in_e), .out(out_e));

  typedef struct {
    logic [7:0] in;
    logic [7:0] exp;
  } vec_c_t;

  typedef struct {
    logic in;
    logic exp;
  } vec_b_t;

  vec_c_t tbl_c [6];
  vec_b_t tbl_b [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for dut_e: inputs captured since the last reset; output is the
  // value taken E_S edges ago, or the reset value if fewer edges have passed.
  logic [E_W-1:0] hist [$];

  function automatic logic [E_W-1:0] model_out();
    if (hist.size() >= E_S) return hist[hist.size() - E_S];
    return E_RV;
  endfunction

  initial begin
    tbl_c[0] = '{8'h11, 8'h00};
    tbl_c[1] = '{8'h22, 8'h00};
    tbl_c[2] = '{8'h33, 8'h11};
    tbl_c[3] = '{8'h44, 8'h22};
    tbl_c[4] = '{8'h00, 8'h33};
    tbl_c[5] = '{8'h00, 8'h44};
    tbl_b[0] = '{1'b1, 1'b1};
    tbl_b[1] = '{1'b0, 1'b0};
    tbl_b[2] = '{1'b1, 1'b1};

    // Async reset of every instance, well before the first clock edge
    #2;
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0; rst_e = 0;
    #1;
    check("init_a", 32'(out_a), 32'h0);
    check("init_b", 32'(out_b), 32'h0);
    check("init_c", 32'(out_c), 32'h0);
    check("init_d", 32'(out_d), 32'hA);
    check("init_e", 32'(out_e), 32'(E_RV));
    tick();
    tick();
    check("hold_d", 32'(out_d), 32'hA);

    // dut_a: capture, then asynchronous reset between edges
    rst_a = 1; in_a = 22'h2AAAAA;
    tick();
    check("a_cap", 32'(out_a), 32'h2AAAAA);
    in_a = 22'h3FFFFF;
    #2 rst_a = 0;
    #1 check("a_async_rst", 32'(out_a), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_rst_hold", 32'(out_a), 32'h0);
    end

    // dut_a: wide data, mid-cycle input change
    rst_a = 1; in_a = 22'h3ABCDE;
    tick();
    check("a_wide", 32'(out_a), 32'h3ABCDE);
    in_a = 22'h000001;
    #2 check("a_midcycle", 32'(out_a), 32'h3ABCDE);
    tick();
    check("a_next", 32'(out_a), 32'h000001);

    // dut_b: plain DFF table
    rst_b = 1;
    for (int i = 0; i < 3; i++) begin
      in_b = tbl_b[i].in;
      tick();
      check("b_tbl", 32'(out_b), 32'(tbl_b[i].exp));
    end
    in_b = 1'b0;
    #2 check("b_midcycle", 32'(out_b), 32'h1);
    tick();
    check("b_after", 32'(out_b), 32'h0);

    // dut_c: three-stage latency table
    rst_c = 1;
    for (int i = 0; i < 6; i++) begin
      in_c = tbl_c[i].in;
      tick();
      check("c_tbl", 32'(out_c), 32'(tbl_c[i].exp));
    end

    // dut_c: reset while 11/22/33 are in flight, then release
    in_c = 8'h11; tick();
    in_c = 8'h22; tick();
    in_c = 8'h33; tick();
    check("c_fill", 32'(out_c), 32'h11);
    rst_c = 0;
    #1 check("c_async_rst", 32'(out_c), 32'h0);
    #1 rst_c = 1; in_c = 8'h55;
    tick(); check("c_rel1", 32'(out_c), 32'h0);
    tick(); check("c_rel2", 32'(out_c), 32'h0);
    tick(); check("c_rel3", 32'(out_c), 32'h55);

    // dut_d: non-zero reset value
    rst_d = 1; in_d = 4'h3;
    tick();
    check("d_cap", 32'(out_d), 32'h3);
    rst_d = 0;
    #1 check("d_async_rst", 32'(out_d), 32'hA);

    // dut_e: randomized data and resets against the queue model
    hist.delete();
    for (int i = 0; i < 400; i++) begin
      int unsigned mode;
      logic [E_W-1:0] v;
      mode = $urandom_range(0, 19);
      v = E_W'($urandom);
      in_e = v;
      if (mode <= 1) begin
        rst_e = 0;
        hist.delete();
        #1 check("e_async_rst", 32'(out_e), 32'(E_RV));
        if (mode == 1) #1 rst_e = 1;
      end else begin
        rst_e = 1;
      end
      tick();
      if (rst_e) begin
        hist.push_back(v);
        if (hist.size() > E_S) void'(hist.pop_front());
      end
      check("e_rand", 32'(out_e), 32'(model_out()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
